// File: rtl/multicycle_ctrl_fsm_pkg.sv
// multicycle_ctrl_fsm_pkg
//   Shared definitions for the TSC multicycle controller: FSM state codes,
//   ALU B-operand select codes, the opcode/func values the controller decodes
//   and instruction-class predicates.
//   TSC opcode map: BNE 0, BEQ 1, BGZ 2, BLZ 3, ADI 4, ORI 5, LHI 6, LWD 7,
//   SWD 8, JMP 9, JAL 10, R-type 15 (func: ALU 0-7, JPR 25, JRL 26, WWD 28, HLT 29).
package multicycle_ctrl_fsm_pkg;

  typedef enum logic [3:0] {
    S_IF   = 4'd0,
    S_ID   = 4'd1,
    S_EX1  = 4'd2,
    S_EX2  = 4'd3,
    S_EX3  = 4'd4,
    S_MEM  = 4'd5,
    S_WB   = 4'd6,
    S_PCU  = 4'd7,
    S_HALT = 4'd8,
    S_ERR  = 4'd9
  } state_e;

  localparam logic [1:0] SRC_B_B   = 2'd0;
  localparam logic [1:0] SRC_B_ONE = 2'd1;
  localparam logic [1:0] SRC_B_IMM = 2'd2;

  localparam logic [3:0] OP_BLZ = 4'd3;
  localparam logic [3:0] OP_ADI = 4'd4;
  localparam logic [3:0] OP_LWD = 4'd7;
  localparam logic [3:0] OP_SWD = 4'd8;
  localparam logic [3:0] OP_JMP = 4'd9;
  localparam logic [3:0] OP_JAL = 4'd10;
  localparam logic [3:0] OP_ALU = 4'd15;

  localparam logic [5:0] FN_JPR = 6'd25;
  localparam logic [5:0] FN_JRL = 6'd26;
  localparam logic [5:0] FN_WWD = 6'd28;
  localparam logic [5:0] FN_HLT = 6'd29;

  // BNE..BLZ occupy opcodes 0..3
  function automatic logic is_branch(input logic [3:0] op);
    return op <= OP_BLZ;
  endfunction

  function automatic logic is_jump(input logic [3:0] op, input logic [5:0] fn);
    return (op == OP_JMP) || (op == OP_JAL) ||
           ((op == OP_ALU) && ((fn == FN_JPR) || (fn == FN_JRL)));
  endfunction

  function automatic logic is_load_store(input logic [3:0] op);
    return (op == OP_LWD) || (op == OP_SWD);
  endfunction

endpackage

// File: rtl/mcc_wait_timer.sv
// mcc_wait_timer
//   Counts consecutive not-ready memory cycles and flags the timeout limit.
//   Ports: clk, reset_n (async low), clr (state entry), inc (stall cycle),
//          hit (count has reached MEM_TIMEOUT; never set when MEM_TIMEOUT==0).
//   TMO_W must satisfy 2**TMO_W > MEM_TIMEOUT.
module mcc_wait_timer #(
  parameter int TMO_W       = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic inc,
  output logic hit
);

  logic [TMO_W-1:0] wait_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  wait_cnt <= '0;
    else if (clr)  wait_cnt <= '0;
    else if (inc)  wait_cnt <= wait_cnt + TMO_W'(1);
  end

  // hit only marks the limit cycle; the FSM decides whether mem_ready rescues it
  assign hit = (MEM_TIMEOUT != 0) && (wait_cnt == TMO_W'(MEM_TIMEOUT));

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm
//   Multicycle control unit for the 16-bit TSC core. Sequences IF/ID/EX1-3/
//   MEM/WB/PCU with a mem_ready handshake, a wait timeout into a sticky ERR
//   state, a sticky HALT state and a retired-instruction counter.
//   Inputs : clk, reset_n (async low), opcode, func_code, bcond, mem_ready
//   Outputs: memory request (mem_read/mem_write/i_or_d), datapath latch enables,
//            ALU operand selects, register-file write controls, pc_write /
//            pc_mux_sel, wwd strobe, halted/mem_err status, num_inst, state.
//   Optional: define MCC_PERF_CNT_EN to add stall_cnt[31:0] (saturating count
//   of IF/MEM cycles with mem_ready low).
module multicycle_ctrl_fsm
  import multicycle_ctrl_fsm_pkg::*;
#(
  parameter int INST_CNT_W  = 16,
  parameter int MEM_TIMEOUT = 15,
  parameter int TMO_W       = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [3:0]            opcode,
  input  logic [5:0]            func_code,
  input  logic                  bcond,
  input  logic                  mem_ready,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  i_or_d,
  output logic                  ir_write,
  output logic                  a_b_write_en,
  output logic                  bcond_write_en,
  output logic                  aluout_write_en,
  output logic                  next_pc_write_en,
  output logic                  alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic                  alu_pc_inc,
  output logic                  reg_write,
  output logic                  mem_to_reg,
  output logic                  wb_sel,
  output logic                  pc_write,
  output logic                  pc_mux_sel,
  output logic                  wwd,
  output logic                  halted,
  output logic                  mem_err,
`ifdef MCC_PERF_CNT_EN
  output logic [31:0]           stall_cnt,
`endif
  output logic [INST_CNT_W-1:0] num_inst,
  output logic [3:0]            state
);

  state_e cur, nxt;
  logic   stalled, tmo_hit;
  logic   op_alu, is_ld, is_st, is_wwd, is_hlt, is_link, to_pcu;

  assign op_alu  = (opcode == OP_ALU);
  assign is_ld   = (opcode == OP_LWD);
  assign is_st   = (opcode == OP_SWD);
  assign is_wwd  = op_alu && (func_code == FN_WWD);
  assign is_hlt  = op_alu && (func_code == FN_HLT);
  assign is_link = (opcode == OP_JAL) || (op_alu && (func_code == FN_JRL));
  // instructions with no register write-back skip WB after EX3
  assign to_pcu  = is_branch(opcode) || (opcode == OP_JMP) || is_wwd ||
                   (op_alu && (func_code == FN_JPR));

  assign stalled = ((cur == S_IF) || (cur == S_MEM)) && !mem_ready;

  // every state change clears the wait count, so IF/MEM always start at zero
  mcc_wait_timer #(.TMO_W(TMO_W), .MEM_TIMEOUT(MEM_TIMEOUT)) u_wait (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (nxt != cur),
    .inc     (stalled),
    .hit     (tmo_hit)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur      <= S_IF;
      num_inst <= '0;
    end else begin
      cur <= nxt;
      if (cur == S_PCU) num_inst <= num_inst + INST_CNT_W'(1);
    end
  end

  always_comb begin
    nxt              = cur;
    mem_read         = 1'b0;
    mem_write        = 1'b0;
    i_or_d           = 1'b0;
    ir_write         = 1'b0;
    a_b_write_en     = 1'b0;
    bcond_write_en   = 1'b0;
    aluout_write_en  = 1'b0;
    next_pc_write_en = 1'b0;
    alu_src_a        = 1'b0;
    alu_src_b        = SRC_B_B;
    alu_pc_inc       = 1'b0;
    reg_write        = 1'b0;
    mem_to_reg       = 1'b0;
    wb_sel           = 1'b0;
    pc_write         = 1'b0;
    wwd              = 1'b0;
    // strobes are forced quiet while reset is held so nothing leaks mid-abort
    if (reset_n) begin
      case (cur)
        S_IF: begin
          mem_read = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            nxt      = S_ID;
          end else if (tmo_hit) begin
            nxt = S_ERR;
          end
        end
        S_ID: begin
          a_b_write_en = 1'b1;
          nxt          = S_EX1;
        end
        S_EX1: begin
          alu_src_a      = 1'b1;
          alu_src_b      = SRC_B_B;
          bcond_write_en = 1'b1;
          wwd            = is_wwd;
          nxt            = is_hlt ? S_HALT : S_EX2;
        end
        S_EX2: begin
          aluout_write_en = 1'b1;
          alu_src_a       = op_alu || ((opcode >= OP_ADI) && (opcode <= OP_SWD));
          alu_src_b       = op_alu ? SRC_B_B : SRC_B_IMM;
          nxt             = S_EX3;
        end
        S_EX3: begin
          next_pc_write_en = 1'b1;
          alu_src_a        = 1'b0;
          alu_src_b        = SRC_B_ONE;
          alu_pc_inc       = !is_jump(opcode, func_code);
          if (to_pcu)                     nxt = S_PCU;
          else if (is_load_store(opcode)) nxt = S_MEM;
          else                            nxt = S_WB;
        end
        S_MEM: begin
          i_or_d    = 1'b1;
          mem_read  = is_ld;
          mem_write = is_st;
          if (mem_ready)    nxt = is_ld ? S_WB : S_PCU;
          else if (tmo_hit) nxt = S_ERR;
        end
        S_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = is_ld;
          wb_sel     = is_link;
          nxt        = S_PCU;
        end
        S_PCU: begin
          pc_write = 1'b1;
          nxt      = S_IF;
        end
        S_HALT, S_ERR: nxt = cur;
        default:       nxt = S_IF;
      endcase
    end
  end

  always_comb begin
    if (is_branch(opcode))             pc_mux_sel = bcond;
    else if (is_jump(opcode, func_code)) pc_mux_sel = 1'b1;
    else                               pc_mux_sel = 1'b0;
  end

  assign halted  = (cur == S_HALT);
  assign mem_err = (cur == S_ERR);
  assign state   = cur;

`ifdef MCC_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                         stall_cnt <= '0;
    else if (stalled && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb_multicycle_ctrl_fsm
//   Self-checking bench. A reference model expands each instruction into the
//   expected per-cycle trace from its instruction class and the stall counts
//   chosen by the bench; the DUT trace is compared cycle by cycle.
//   DUT built with INST_CNT_W=2, MEM_TIMEOUT=3, TMO_W=2.
module tb_multicycle_ctrl_fsm;
  import multicycle_ctrl_fsm_pkg::*;

  localparam int CW = 2;

  logic clk = 1'b0, reset_n = 1'b0;
  logic [3:0] opcode = '0;
  logic [5:0] func_code = '0;
  logic bcond = 1'b0, mem_ready = 1'b0;
  logic mem_read, mem_write, i_or_d, ir_write, a_b_write_en, bcond_write_en;
  logic aluout_write_en, next_pc_write_en, alu_src_a, alu_pc_inc;
  logic [1:0] alu_src_b;
  logic reg_write, mem_to_reg, wb_sel, pc_write, pc_mux_sel, wwd, halted, mem_err;
  logic [CW-1:0] num_inst;
  logic [3:0] state;
`ifdef MCC_PERF_CNT_EN
  logic [31:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  multicycle_ctrl_fsm #(.INST_CNT_W(CW), .MEM_TIMEOUT(3), .TMO_W(2)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .func_code(func_code),
    .bcond(bcond), .mem_ready(mem_ready), .mem_read(mem_read), .mem_write(mem_write),
    .i_or_d(i_or_d), .ir_write(ir_write), .a_b_write_en(a_b_write_en),
    .bcond_write_en(bcond_write_en), .aluout_write_en(aluout_write_en),
    .next_pc_write_en(next_pc_write_en), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_pc_inc(alu_pc_inc), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .wb_sel(wb_sel), .pc_write(pc_write), .pc_mux_sel(pc_mux_sel), .wwd(wwd),
    .halted(halted), .mem_err(mem_err),
`ifdef MCC_PERF_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .num_inst(num_inst), .state(state)
  );

  typedef struct packed {
    logic mr, mw, iod, irw, abw, bcw, aow, npw, rw, m2r, wbs, pcw, wwd, inc;
  } strb_t;

  strb_t cur_sb;
  assign cur_sb = {mem_read, mem_write, i_or_d, ir_write, a_b_write_en, bcond_write_en,
                   aluout_write_en, next_pc_write_en, reg_write, mem_to_reg, wb_sel,
                   pc_write, wwd, alu_pc_inc};

  int n_tests = 0, n_fail = 0, exp_cnt = 0;

  logic [3:0] exp_st[$], obs_st[$], exp_sel[$], exp_msk[$], obs_sel[$];
  strb_t      exp_sb[$], obs_sb[$];
  logic       exp_rdy[$];

  task automatic add(input state_e st, input strb_t sb, input logic [3:0] sel,
                     input logic [3:0] msk, input logic rdy);
    exp_st.push_back(st); exp_sb.push_back(sb); exp_sel.push_back(sel & msk);
    exp_msk.push_back(msk); exp_rdy.push_back(rdy);
  endtask

  // Expected trace: sel = {alu_src_a, alu_src_b, pc_mux_sel}, masked per cycle.
  task automatic model(input logic [3:0] op, input logic [5:0] fn, input logic bc,
                       input int ifst, input int memst);
    bit alu  = (op == 4'd15);
    bit ld   = (op == 4'd7);
    bit st   = (op == 4'd8);
    bit br   = (op <= 4'd3);
    bit jp   = (op == 4'd9) || (op == 4'd10) || (alu && (fn == 6'd25 || fn == 6'd26));
    bit lnk  = (op == 4'd10) || (alu && fn == 6'd26);
    bit wwdi = alu && (fn == 6'd28);
    bit hlt  = alu && (fn == 6'd29);
    bit wb   = !(br || op == 4'd9 || st || (alu && (fn == 6'd25 || fn == 6'd28)));
    logic pm = br ? bc : jp;
    strb_t s;
    exp_st.delete(); exp_sb.delete(); exp_sel.delete(); exp_msk.delete(); exp_rdy.delete();
    for (int i = 0; i <= ifst; i++) begin
      s = '0; s.mr = 1'b1; s.irw = (i == ifst);
      add(S_IF, s, 4'd0, 4'd0, i == ifst);
    end
    s = '0; s.abw = 1'b1; add(S_ID, s, 4'd0, 4'd0, 1'($urandom_range(0, 1)));
    s = '0; s.bcw = 1'b1; s.wwd = wwdi;
    add(S_EX1, s, {1'b1, 2'd0, 1'b0}, 4'b1110, 1'($urandom_range(0, 1)));
    if (hlt) return;
    s = '0; s.aow = 1'b1;
    add(S_EX2, s, {alu || (op >= 4'd4 && op <= 4'd8), alu ? 2'd0 : 2'd2, 1'b0}, 4'b1110,
        1'($urandom_range(0, 1)));
    s = '0; s.npw = 1'b1; s.inc = !jp;
    add(S_EX3, s, {1'b0, 2'd1, pm}, 4'b1111, 1'($urandom_range(0, 1)));
    if (ld || st)
      for (int i = 0; i <= memst; i++) begin
        s = '0; s.iod = 1'b1; s.mr = ld; s.mw = st;
        add(S_MEM, s, 4'd0, 4'd0, i == memst);
      end
    if (ld || wb) begin
      s = '0; s.rw = 1'b1; s.m2r = ld; s.wbs = lnk;
      add(S_WB, s, 4'd0, 4'd0, 1'($urandom_range(0, 1)));
    end
    s = '0; s.pcw = 1'b1;
    add(S_PCU, s, {3'b000, pm}, 4'b0001, 1'($urandom_range(0, 1)));
  endtask

  // Drive one instruction along the model's mem_ready schedule and record outputs.
  task automatic exec(input logic [3:0] op, input logic [5:0] fn, input logic bc);
    opcode = op; func_code = fn; bcond = bc;
    obs_st.delete(); obs_sb.delete(); obs_sel.delete();
    foreach (exp_st[k]) begin
      mem_ready = exp_rdy[k];
      #1;
      obs_st.push_back(state); obs_sb.push_back(cur_sb);
      obs_sel.push_back({alu_src_a, alu_src_b, pc_mux_sel} & exp_msk[k]);
      @(posedge clk); #2;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    reset_n = 1'b0; #3; reset_n = 1'b1;
    exp_cnt = 0;
  endtask

  task automatic test_instr(input string nm, input logic [3:0] op, input logic [5:0] fn,
                            input logic bc, input int ifst, input int memst);
    model(op, fn, bc, ifst, memst);
    exec(op, fn, bc);
    foreach (exp_st[k]) begin
      n_tests++;
      if (obs_st[k] !== exp_st[k] || obs_sb[k] !== exp_sb[k] || obs_sel[k] !== exp_sel[k]) begin
        n_fail++;
        $display("FAIL %s cyc%0d: got st=%0d strb=%h sel=%h, want st=%0d strb=%h sel=%h",
                 nm, k, obs_st[k], obs_sb[k], obs_sel[k], exp_st[k], exp_sb[k], exp_sel[k]);
      end
    end
    if (!(op == 4'd15 && fn == 6'd29)) exp_cnt++;
    n_tests++;
    if (num_inst !== CW'(exp_cnt)) begin
      n_fail++;
      $display("FAIL %s num_inst: got %0d want %0d", nm, num_inst, CW'(exp_cnt));
    end
  endtask

  task automatic test_reset();
    @(posedge clk); @(posedge clk); #2;
    n_tests += 3;
    if (state !== S_IF || num_inst !== '0) begin
      n_fail++; $display("FAIL reset state/cnt: got %0d/%0d want %0d/0", state, num_inst, S_IF);
    end
    if (halted !== 1'b0 || mem_err !== 1'b0) begin
      n_fail++; $display("FAIL reset status: got halted=%b err=%b want 0/0", halted, mem_err);
    end
    if (cur_sb !== '0) begin
      n_fail++; $display("FAIL reset strobes: got %h want 0", cur_sb);
    end
    reset_n = 1'b1;
    exp_cnt = 0;
  endtask

  task automatic test_adi();
    test_instr("adi", 4'd4, 6'($urandom), 1'b0, 0, 0);
  endtask

  task automatic test_lwd_stall();
    int n = 0;
    test_instr("lwd_stall", 4'd7, 6'($urandom), 1'b0, 0, 3);
    foreach (obs_sb[k]) if (obs_sb[k].mr && obs_sb[k].iod) n++;
    n_tests++;
    if (n !== 4) begin
      n_fail++; $display("FAIL lwd_hold: got %0d data-read cycles want 4", n);
    end
  endtask

  task automatic test_branch();
    test_instr("bne_taken", 4'd0, 6'($urandom), 1'b1, 0, 0);
    test_instr("bne_not",   4'd0, 6'($urandom), 1'b0, 0, 0);
  endtask

  task automatic test_timeout();
    do_reset();
    opcode = 4'd15; func_code = 6'd0; mem_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1; n_tests++;
      if (state !== S_IF) begin
        n_fail++; $display("FAIL tmo_wait%0d: got st=%0d want %0d", k, state, S_IF);
      end
      @(posedge clk); #2;
    end
    mem_ready = 1'b1; @(posedge clk); #2;
    n_tests++;
    if (state !== S_ERR || mem_err !== 1'b1 || cur_sb !== '0) begin
      n_fail++;
      $display("FAIL tmo_err: got st=%0d err=%b strb=%h want %0d/1/0", state, mem_err, cur_sb, S_ERR);
    end
`ifdef MCC_PERF_CNT_EN
    n_tests++;
    if (stall_cnt !== 32'd4) begin
      n_fail++; $display("FAIL stall_cnt: got %0d want 4", stall_cnt);
    end
`endif
    do_reset();
    mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2; mem_ready = 1'b1; #1;
    n_tests++;
    if (state !== S_IF || ir_write !== 1'b1) begin
      n_fail++; $display("FAIL tmo_limit_ready: got st=%0d irw=%b want %0d/1", state, ir_write, S_IF);
    end
    @(posedge clk); #2;
    n_tests++;
    if (state !== S_ID || mem_err !== 1'b0) begin
      n_fail++; $display("FAIL tmo_rescue: got st=%0d err=%b want %0d/0", state, mem_err, S_ID);
    end
  endtask

  task automatic test_halt_reset();
    do_reset();
    test_instr("halt_i0", 4'd15, 6'd0, 1'b0, 1, 0);
    test_instr("halt_i1", 4'd4, 6'($urandom), 1'b0, 0, 0);
    test_instr("hlt", 4'd15, 6'd29, 1'b0, 2, 0);
    for (int k = 0; k < 4; k++) begin
      mem_ready = 1'($urandom_range(0, 1)); #1;
      n_tests++;
      if (state !== S_HALT || halted !== 1'b1 || num_inst !== CW'(2) || cur_sb !== '0) begin
        n_fail++;
        $display("FAIL halt_hold%0d: got st=%0d halted=%b cnt=%0d strb=%h want %0d/1/2/0",
                 k, state, halted, num_inst, cur_sb, S_HALT);
      end
      @(posedge clk); #2;
    end
    do_reset();
    test_instr("pre_abort", 4'd15, 6'd1, 1'b0, 0, 0);
    opcode = 4'd15; func_code = 6'd2; mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2; n_tests++;
    if (state !== S_EX2) begin
      n_fail++; $display("FAIL abort_setup: got st=%0d want %0d", state, S_EX2);
    end
    #1 reset_n = 1'b0;
    #1 n_tests++;
    if (state !== S_IF || num_inst !== '0 || halted !== 1'b0 || cur_sb !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got st=%0d cnt=%0d halted=%b strb=%h want %0d/0/0/0",
               state, num_inst, halted, cur_sb, S_IF);
    end
    #1 reset_n = 1'b1; exp_cnt = 0;
    #1 n_tests++;
    if (reg_write !== 1'b0 || pc_write !== 1'b0 || state !== S_IF) begin
      n_fail++;
      $display("FAIL post_abort: got rw=%b pcw=%b st=%0d want 0/0/%0d", reg_write, pc_write, state, S_IF);
    end
  endtask

  task automatic test_counter_wrap();
    int seq[5] = '{1, 2, 3, 0, 1};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      test_instr("wrap", 4'd15, 6'($urandom_range(0, 7)), 1'b0, 0, 0);
      n_tests++;
      if (num_inst !== CW'(seq[i])) begin
        n_fail++; $display("FAIL wrap_seq%0d: got %0d want %0d", i, num_inst, seq[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] op;
    logic [5:0] fn;
    int idx;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 11));
      if (op == 4'd11) op = 4'd15;
      idx = $urandom_range(0, 10);
      fn = (op != 4'd15) ? 6'($urandom) :
           (idx < 8) ? 6'(idx) : (idx == 8) ? 6'd25 : (idx == 9) ? 6'd26 : 6'd28;
      test_instr("random", op, fn, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3), $urandom_range(0, 3));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_adi();
    test_lwd_stall();
    test_branch();
    test_timeout();
    test_halt_reset();
    test_counter_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
